// File: rtl/azel_axil_pkg.sv
// rtl/azel_axil_pkg.sv - shared FSM states, AXI response codes and defaults for the arbiter
package azel_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } azel_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int AZEL_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/azel_rr_arb2.sv
// rtl/azel_rr_arb2.sv - two-input round-robin arbiter with last-grant register
module azel_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_gnt_valid,
    output logic       o_gnt_id,
    output logic       o_last_id
);

    logic r_last;
    logic w_id;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_id = 1'b0;
        if (i_req == 2'b11) begin
            w_id = ~r_last;
        end else if (i_req[1]) begin
            w_id = 1'b1;
        end
    end

    assign o_gnt_valid = |i_req;
    assign o_gnt_id    = w_id;
    assign o_last_id   = r_last;

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_en && o_gnt_valid) begin
            r_last <= w_id;
        end
    end

endmodule

// File: rtl/azel_axil_arbiter.sv
// rtl/azel_axil_arbiter.sv - two-requester AXI4-Lite master with round-robin grant and timeout
module azel_axil_arbiter
    import azel_axil_pkg::*;
#(
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT            = AZEL_DEFAULT_TIMEOUT
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic                              REQ0_VALID,
    input  logic                              REQ0_WE,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   REQ0_ADDR,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   REQ0_WDATA,
    output logic                              REQ0_DONE,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   REQ0_RDATA,
    output logic [1:0]                        REQ0_RESP,

    input  logic                              REQ1_VALID,
    input  logic                              REQ1_WE,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   REQ1_ADDR,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   REQ1_WDATA,
    output logic                              REQ1_DONE,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   REQ1_RDATA,
    output logic [1:0]                        REQ1_RESP,

    output logic [C_S00_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_S00_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_S00_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,

    output logic                              BUSY,
    output logic                              GRANT_ID
);

    localparam int CNT_W = $clog2(C_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT - 1);
    localparam logic [C_S00_AXI_ADDR_WIDTH-1:0] ADDR_LSB_MASK = C_S00_AXI_ADDR_WIDTH'(3);

    logic [1:0]                      r_rst_sync;
    logic                            w_rst_n;
    azel_state_e                     r_state;
    azel_state_e                     w_next;
    logic [CNT_W-1:0]                r_cnt;
    logic [C_S00_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_wdata;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata0;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata1;
    logic [1:0]                      r_resp0;
    logic [1:0]                      r_resp1;

    logic                            w_gnt_en;
    logic                            w_gnt_valid;
    logic                            w_gnt_id;
    logic                            w_last_id;
    logic [1:0]                      w_req;
    logic                            w_sel_we;
    logic [C_S00_AXI_ADDR_WIDTH-1:0] w_sel_addr;
    logic [C_S00_AXI_DATA_WIDTH-1:0] w_sel_wdata;
    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_b_hs;
    logic                            w_ar_hs;
    logic                            w_r_hs;
    logic                            w_counting;
    logic                            w_timeout;
    logic                            w_done;

    // Reset asserts immediately and releases two clocks after ARESETN rises.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n  = r_rst_sync[1];
    assign w_req    = {REQ1_VALID, REQ0_VALID} & {2{w_rst_n}};
    assign w_gnt_en = (r_state == ST_IDLE);

    azel_rr_arb2 u_arb (
        .i_clk       (ACLK),
        .i_rst_n     (w_rst_n),
        .i_req       (w_req),
        .i_en        (w_gnt_en),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id),
        .o_last_id   (w_last_id)
    );

    assign w_sel_we    = w_gnt_id ? REQ1_WE    : REQ0_WE;
    assign w_sel_addr  = w_gnt_id ? REQ1_ADDR  : REQ0_ADDR;
    assign w_sel_wdata = w_gnt_id ? REQ1_WDATA : REQ0_WDATA;

    assign w_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
    assign w_b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
    assign w_ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign w_r_hs  = M_AXI_RVALID  & M_AXI_RREADY;

    assign w_counting = (r_state == ST_WR) || (r_state == ST_WR_RESP) ||
                        (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);
    assign w_timeout  = w_counting && (r_cnt == CNT_LAST);

    always_ff @(posedge ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_next = w_sel_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                // AW and W retire independently; leave only once both have.
                M_AXI_AWVALID = ~r_aw_done;
                M_AXI_WVALID  = ~r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next = ST_WR_RESP;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (w_b_hs || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (w_ar_hs) begin
                    w_next = ST_RD_DATA;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (w_r_hs || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_resp0   <= AXI_RESP_OKAY;
            r_resp1   <= AXI_RESP_OKAY;
            r_cnt     <= '0;
        end else begin
            if (w_gnt_en && w_gnt_valid) begin
                r_addr    <= w_sel_addr & ~ADDR_LSB_MASK;
                r_wdata   <= w_sel_we ? w_sel_wdata : '0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (r_state == ST_WR) begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end

            // Result lands on entry to DONE so it is valid during the pulse.
            if (r_state != ST_DONE && w_next == ST_DONE) begin
                if (w_last_id) begin
                    r_rdata1 <= w_r_hs ? M_AXI_RDATA : '0;
                    r_resp1  <= w_b_hs ? M_AXI_BRESP :
                                w_r_hs ? M_AXI_RRESP : AXI_RESP_SLVERR;
                end else begin
                    r_rdata0 <= w_r_hs ? M_AXI_RDATA : '0;
                    r_resp0  <= w_b_hs ? M_AXI_BRESP :
                                w_r_hs ? M_AXI_RRESP : AXI_RESP_SLVERR;
                end
            end

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign M_AXI_AWADDR = r_addr;
    assign M_AXI_ARADDR = r_addr;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = r_wdata;
    assign M_AXI_WSTRB  = '1;

    assign REQ0_DONE  = w_done & ~w_last_id;
    assign REQ1_DONE  = w_done &  w_last_id;
    assign REQ0_RDATA = r_rdata0;
    assign REQ1_RDATA = r_rdata1;
    assign REQ0_RESP  = r_resp0;
    assign REQ1_RESP  = r_resp1;

    assign BUSY     = (r_state != ST_IDLE) || w_gnt_valid;
    assign GRANT_ID = (w_gnt_en && w_gnt_valid) ? w_gnt_id : w_last_id;

endmodule

// File: tb/tb_azel_axil_arbiter.sv
// tb/tb_azel_axil_arbiter.sv - directed bench for azel_axil_arbiter with a behavioural AXI-Lite slave
module tb_azel_axil_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          ACLK    = 1'b0;
    logic          ARESETN = 1'b1;

    logic          REQ0_VALID = 1'b0;
    logic          REQ0_WE    = 1'b0;
    logic [AW-1:0] REQ0_ADDR  = '0;
    logic [DW-1:0] REQ0_WDATA = '0;
    logic          REQ0_DONE;
    logic [DW-1:0] REQ0_RDATA;
    logic [1:0]    REQ0_RESP;
    logic          REQ1_VALID = 1'b0;
    logic          REQ1_WE    = 1'b0;
    logic [AW-1:0] REQ1_ADDR  = '0;
    logic [DW-1:0] REQ1_WDATA = '0;
    logic          REQ1_DONE;
    logic [DW-1:0] REQ1_RDATA;
    logic [1:0]    REQ1_RESP;

    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY = 1'b0;
    logic [DW-1:0] M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY = 1'b0;
    logic [1:0]    M_AXI_BRESP = 2'b00;
    logic          M_AXI_BVALID = 1'b0;
    logic          M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [DW-1:0] M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = 2'b00;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_RREADY;
    logic          BUSY;
    logic          GRANT_ID;

    azel_axil_arbiter #(
        .C_S00_AXI_ADDR_WIDTH (AW),
        .C_S00_AXI_DATA_WIDTH (DW),
        .C_TIMEOUT            (TMO)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .REQ0_VALID    (REQ0_VALID),
        .REQ0_WE       (REQ0_WE),
        .REQ0_ADDR     (REQ0_ADDR),
        .REQ0_WDATA    (REQ0_WDATA),
        .REQ0_DONE     (REQ0_DONE),
        .REQ0_RDATA    (REQ0_RDATA),
        .REQ0_RESP     (REQ0_RESP),
        .REQ1_VALID    (REQ1_VALID),
        .REQ1_WE       (REQ1_WE),
        .REQ1_ADDR     (REQ1_ADDR),
        .REQ1_WDATA    (REQ1_WDATA),
        .REQ1_DONE     (REQ1_DONE),
        .REQ1_RDATA    (REQ1_RDATA),
        .REQ1_RESP     (REQ1_RESP),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .BUSY          (BUSY),
        .GRANT_ID      (GRANT_ID)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration (written by the stimulus) and slave/monitor state.
    int         aw_delay = 0;
    bit         ar_block = 1'b0;
    bit         sl_clear = 1'b1;
    logic [31:0] mem [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    bit         p_aw, p_w, p_b, p_ar, p_r, got_aw, got_w, rd_pend;
    logic [3:0] aw_addr_q, ar_addr_q, last_awaddr, last_wstrb;
    logic [31:0] wd_q;
    int         aw_wait, aw_cycles, w_cycles, ar_cycles, b_hs, done0_cnt, done1_cnt;

    // Handshakes predicted at one falling edge take effect at the next one.
    always @(negedge ACLK) begin
        if (sl_clear) begin
            p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
            got_aw = 0; got_w = 0; rd_pend = 0; aw_wait = 0;
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
        end else begin
            if (p_aw) got_aw = 1;
            if (p_w)  got_w = 1;
            if (p_b)  M_AXI_BVALID = 0;
            if (p_ar) rd_pend = 1;
            if (p_r)  M_AXI_RVALID = 0;
            if (got_aw && got_w && !M_AXI_BVALID) begin
                mem[aw_addr_q[3:2]] = wd_q;
                M_AXI_BRESP = 2'b00;
                M_AXI_BVALID = 1;
                got_aw = 0;
                got_w = 0;
            end
            if (rd_pend && !M_AXI_RVALID) begin
                M_AXI_RDATA = mem[ar_addr_q[3:2]];
                M_AXI_RRESP = 2'b00;
                M_AXI_RVALID = 1;
                rd_pend = 0;
            end
            if (M_AXI_AWVALID) aw_cycles++;
            if (M_AXI_WVALID)  w_cycles++;
            if (M_AXI_ARVALID) ar_cycles++;
            M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_delay);
            if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait++;
            else aw_wait = 0;
            M_AXI_WREADY  = M_AXI_WVALID;
            M_AXI_ARREADY = M_AXI_ARVALID && !ar_block;
            p_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            if (p_aw) begin aw_addr_q = M_AXI_AWADDR; last_awaddr = M_AXI_AWADDR; end
            p_w = M_AXI_WVALID && M_AXI_WREADY;
            if (p_w) begin wd_q = M_AXI_WDATA; last_wstrb = M_AXI_WSTRB; end
            p_b = M_AXI_BVALID && M_AXI_BREADY;
            if (p_b) b_hs++;
            p_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            if (p_ar) ar_addr_q = M_AXI_ARADDR;
            p_r = M_AXI_RVALID && M_AXI_RREADY;
        end
        if (REQ0_DONE) done0_cnt++;
        if (REQ1_DONE) done1_cnt++;
    end

    task automatic do_txn(input int id, input bit we, input logic [3:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic [1:0] resp,
                          output bit fv);
        lat = 0; rdata = '0; resp = '0; fv = 0;
        @(negedge ACLK);
        if (id == 0) begin
            REQ0_VALID = 1; REQ0_WE = we; REQ0_ADDR = addr; REQ0_WDATA = wd;
        end else begin
            REQ1_VALID = 1; REQ1_WE = we; REQ1_ADDR = addr; REQ1_WDATA = wd;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge ACLK);
            if (k == 1) begin
                fv = we ? (M_AXI_AWVALID && M_AXI_WVALID) : M_AXI_ARVALID;
                if (id == 0) begin
                    REQ0_VALID = 0; REQ0_WE = ~we; REQ0_ADDR = ~addr; REQ0_WDATA = ~wd;
                end else begin
                    REQ1_VALID = 0; REQ1_WE = ~we; REQ1_ADDR = ~addr; REQ1_WDATA = ~wd;
                end
            end
            if (id == 0 ? REQ0_DONE : REQ1_DONE) begin
                lat   = k;
                rdata = (id == 0) ? REQ0_RDATA : REQ1_RDATA;
                resp  = (id == 0) ? REQ0_RESP : REQ1_RESP;
                break;
            end
        end
    endtask

    initial begin
        int          lat, nd, s_aw, s_w, s_b, s_d, s_ar;
        int          ord[4];
        int          dk[4];
        logic [31:0] rd;
        logic [1:0]  rs;
        bit          fv;

        repeat (3) @(negedge ACLK);
        ARESETN = 0;
        repeat (3) @(negedge ACLK);
        check("rst_busy", BUSY, 0);
        check("rst_grant_id", GRANT_ID, 1);
        check("rst_done", {REQ0_DONE, REQ1_DONE}, 0);
        check("rst_rdata", REQ0_RDATA | REQ1_RDATA, 0);
        check("rst_resp", {REQ0_RESP, REQ1_RESP}, 0);
        check("rst_handshake", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        ARESETN = 1;
        sl_clear = 0;
        repeat (3) @(negedge ACLK);

        // Simultaneous reads held high: strict alternation starting with requester 0.
        for (int i = 0; i < 4; i++) begin ord[i] = 9; dk[i] = 0; end
        nd = 0;
        REQ0_VALID = 1; REQ0_WE = 0; REQ0_ADDR = 4'h8;
        REQ1_VALID = 1; REQ1_WE = 0; REQ1_ADDR = 4'hC;
        for (int k = 1; k <= 40 && nd < 4; k++) begin
            @(negedge ACLK);
            if (REQ0_DONE || REQ1_DONE) begin
                ord[nd] = REQ1_DONE ? 1 : 0;
                dk[nd]  = k;
                if (REQ0_DONE) check("tie_rdata0", REQ0_RDATA, 32'h3333_0002);
                else           check("tie_rdata1", REQ1_RDATA, 32'h4444_0003);
                nd++;
                if (nd == 4) begin REQ0_VALID = 0; REQ1_VALID = 0; end
            end
        end
        REQ0_VALID = 0; REQ1_VALID = 0;
        check("tie_count", nd, 4);
        for (int i = 0; i < 4; i++) check("tie_order", ord[i], i % 2);
        check("tie_first_lat", dk[0], 3);
        for (int i = 1; i < 4; i++) check("tie_gap", dk[i] - dk[i-1], 4);

        // Zero-wait write then readback by requester 0.
        do_txn(0, 1, 4'h4, 32'h0000_00A5, lat, rd, rs, fv);
        check("wr0_first_valid", fv, 1);
        check("wr0_lat", lat, 3);
        check("wr0_resp", rs, 0);
        check("wr0_rdata", rd, 0);
        do_txn(0, 0, 4'h4, 32'h0, lat, rd, rs, fv);
        check("rd0_first_valid", fv, 1);
        check("rd0_lat", lat, 3);
        check("rd0_rdata", rd, 32'h0000_00A5);
        check("rd0_resp", rs, 0);

        // Unaligned write from requester 1 lands at the word address.
        do_txn(1, 1, 4'h7, 32'h1234_5678, lat, rd, rs, fv);
        #1;
        check("wr1_lat", lat, 3);
        check("wr1_resp", rs, 0);
        check("wr1_awaddr", last_awaddr, 4'h4);
        check("wr1_wstrb", last_wstrb, 4'hF);
        check("rdata0_hold", REQ0_RDATA, 32'h0000_00A5);
        do_txn(1, 0, 4'h6, 32'h0, lat, rd, rs, fv);
        check("rd1_rdata", rd, 32'h1234_5678);

        // AWREADY delayed three cycles, WREADY immediate.
        aw_delay = 3;
        #1;
        s_aw = aw_cycles; s_w = w_cycles; s_b = b_hs; s_d = done1_cnt;
        do_txn(1, 1, 4'h8, 32'h5555_AAAA, lat, rd, rs, fv);
        check("awdly_lat", lat, 6);
        check("awdly_resp", rs, 0);
        repeat (3) @(negedge ACLK);
        #1;
        check("awdly_aw_cycles", aw_cycles - s_aw, 4);
        check("awdly_w_cycles", w_cycles - s_w, 1);
        check("awdly_b_hs", b_hs - s_b, 1);
        check("awdly_done_once", done1_cnt - s_d, 1);
        aw_delay = 0;

        // ARREADY never arrives: timeout after TMO cycles with SLVERR.
        ar_block = 1;
        s_ar = ar_cycles;
        do_txn(0, 0, 4'h0, 32'h0, lat, rd, rs, fv);
        check("tmo_lat", lat, TMO + 1);
        check("tmo_resp", rs, 2'b10);
        check("tmo_rdata", rd, 0);
        repeat (2) @(negedge ACLK);
        #1;
        check("tmo_ar_cycles", ar_cycles - s_ar, TMO);
        ar_block = 0;

        do_txn(1, 0, 4'h8, 32'h0, lat, rd, rs, fv);
        check("rd1b_rdata", rd, 32'h5555_AAAA);

        // Reset while waiting for B: everything drops at once, no DONE.
        @(negedge ACLK);
        REQ0_VALID = 1; REQ0_WE = 1; REQ0_ADDR = 4'h0; REQ0_WDATA = 32'h0000_DEAD;
        @(negedge ACLK);
        REQ0_VALID = 0;
        @(negedge ACLK);
        check("pre_rst_bready", M_AXI_BREADY, 1);
        #1;
        ARESETN = 0;
        sl_clear = 1;
        #1;
        check("rst2_bready", M_AXI_BREADY, 0);
        check("rst2_busy", BUSY, 0);
        check("rst2_grant_id", GRANT_ID, 1);
        check("rst2_rdata1", REQ1_RDATA, 0);
        check("rst2_resp0", REQ0_RESP, 0);
        s_d = done0_cnt;
        repeat (4) @(negedge ACLK);
        #1;
        check("rst2_no_done", done0_cnt - s_d, 0);
        @(negedge ACLK);
        ARESETN = 1;
        sl_clear = 0;
        repeat (3) @(negedge ACLK);
        do_txn(1, 1, 4'hC, 32'hCAFE_F00D, lat, rd, rs, fv);
        check("post_rst_wr_lat", lat, 3);
        check("post_rst_wr_resp", rs, 0);
        do_txn(0, 0, 4'hC, 32'h0, lat, rd, rs, fv);
        check("post_rst_rd_lat", lat, 3);
        check("post_rst_rd_rdata", rd, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
